// File: rtl/alu_in_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_in_issue_pkg
// Description : Shared types for the ALU input issuer. It holds the 3-bit
//               operation encoding seen on the ALU input port and the
//               issue-FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_in_issue_pkg;

    localparam int ALU_IN_OP_ENC_WIDTH = 3;

    typedef enum logic [ALU_IN_OP_ENC_WIDTH-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } alu_in_op_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        RST_ASSERT  = 2'd2,
        RST_RECOVER = 2'd3
    } issue_state_t;

endpackage : alu_in_issue_pkg
`default_nettype wire

// File: rtl/alu_in_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_in_issue_ctrl_if
// Description : Bundle of the request-side and ALU-side signals of the ALU
//               input issuer.
//               master : traffic source / ALU model (drives requests, alu_ready)
//               slave  : alu_in_issue_ctrl
//               Signals: ch_valid/ch_ready/ch_op/ch_a/ch_b (per-channel request
//               handshake, channel i in slice i), alu_rst (active-low ALU
//               reset), alu_ready/alu_valid/alu_op/alu_a/alu_b (issue port),
//               busy and fifo_count (status).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_in_issue_ctrl_if #(
    parameter int OP_WIDTH   = 8,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
);
    import alu_in_issue_pkg::*;

    logic [NUM_CH-1:0]                     ch_valid;
    logic [NUM_CH-1:0]                     ch_ready;
    logic [ALU_IN_OP_ENC_WIDTH*NUM_CH-1:0] ch_op;
    logic [OP_WIDTH*NUM_CH-1:0]            ch_a;
    logic [OP_WIDTH*NUM_CH-1:0]            ch_b;
    logic                                  alu_rst;
    logic                                  alu_ready;
    logic                                  alu_valid;
    logic [ALU_IN_OP_ENC_WIDTH-1:0]        alu_op;
    logic [OP_WIDTH-1:0]                   alu_a;
    logic [OP_WIDTH-1:0]                   alu_b;
    logic                                  busy;
    logic [$clog2(FIFO_DEPTH):0]           fifo_count;

    modport master (
        output ch_valid, ch_op, ch_a, ch_b, alu_ready,
        input  ch_ready, alu_rst, alu_valid, alu_op, alu_a, alu_b, busy, fifo_count
    );

    modport slave (
        input  ch_valid, ch_op, ch_a, ch_b, alu_ready,
        output ch_ready, alu_rst, alu_valid, alu_op, alu_a, alu_b, busy, fifo_count
    );

endinterface : alu_in_issue_ctrl_if
`default_nettype wire

// File: rtl/alu_in_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_in_issue_fifo
// Description : Synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH a power
//               of two). Head entry is presented combinationally on o_data.
//               Ports: clk, rst (sync, active-high), i_push/i_data,
//               i_pop, o_data, o_full, o_empty, o_count.
//               A push while full or a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_in_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : alu_in_issue_fifo
`default_nettype wire

// File: rtl/alu_in_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_in_issue_ctrl
// Description : Multi-channel ALU input issuer. NUM_CH requesters are
//               arbitrated round-robin into a shared FIFO; the issue FSM pops
//               entries and drives them to the ALU as one-cycle alu_valid
//               pulses, or runs the alu_rst sequence when a rst_op reaches
//               the head.
//               Ports: clk, rst (sync, active-high), bus (slave modport of
//               alu_in_issue_ctrl_if: request channels, ALU issue port,
//               busy, fifo_count).
//               Optional: define ALU_IN_ISSUE_STATS_EN to add the saturating
//               16-bit issued_count / reset_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_in_issue_ctrl #(
    parameter int OP_WIDTH           = 8,
    parameter int NUM_CH             = 2,
    parameter int FIFO_DEPTH         = 4,
    parameter int RST_ASSERT_CYCLES  = 10,
    parameter int RST_RECOVER_CYCLES = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_in_issue_ctrl_if.slave  bus
`ifdef ALU_IN_ISSUE_STATS_EN
    ,
    output logic [15:0]         issued_count,
    output logic [15:0]         reset_count
`endif
);
    import alu_in_issue_pkg::*;

    localparam int c_OPW     = ALU_IN_OP_ENC_WIDTH;
    localparam int c_ENTRY_W = c_OPW + 2 * OP_WIDTH;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_RC_MAX  = (RST_ASSERT_CYCLES > RST_RECOVER_CYCLES) ?
                               RST_ASSERT_CYCLES : RST_RECOVER_CYCLES;
    localparam int c_RC_W    = $clog2(c_RC_MAX + 1);
    localparam logic [c_RC_W-1:0] c_RA_LOAD = c_RC_W'(RST_ASSERT_CYCLES - 1);
    localparam logic [c_RC_W-1:0] c_RR_LOAD = c_RC_W'(RST_RECOVER_CYCLES - 1);

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic                 w_found;
    logic                 w_push;
    logic [NUM_CH-1:0]    w_ready;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0] w_head;

    function automatic logic [c_PTR_W-1:0] f_wrap(input int i_sum);
        return (i_sum >= NUM_CH) ? c_PTR_W'(i_sum - NUM_CH) : c_PTR_W'(i_sum);
    endfunction

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        logic [c_PTR_W-1:0] w_cand;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = f_wrap(int'(r_rr_ptr) + k);
            if (!w_found && bus.ch_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // No bypass: a full FIFO refuses pushes even if the FSM pops this cycle.
    assign w_push = !rst && !w_full && w_found;

    always_comb begin
        w_ready = '0;
        if (w_push) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign bus.ch_ready = w_ready;
    assign w_push_data  = {
        bus.ch_op[int'(w_grant_idx) * c_OPW +: c_OPW],
        bus.ch_a[int'(w_grant_idx) * OP_WIDTH +: OP_WIDTH],
        bus.ch_b[int'(w_grant_idx) * OP_WIDTH +: OP_WIDTH]
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= f_wrap(int'(w_grant_idx) + 1);
        end
    end

    // ------------------------------------------------------------------
    // Shared request queue
    // ------------------------------------------------------------------
    logic w_pop;

    alu_in_issue_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    logic [c_OPW-1:0]    w_head_op;
    logic [OP_WIDTH-1:0] w_head_a;
    logic [OP_WIDTH-1:0] w_head_b;

    assign w_head_op = w_head[c_ENTRY_W-1 -: c_OPW];
    assign w_head_a  = w_head[2*OP_WIDTH-1 -: OP_WIDTH];
    assign w_head_b  = w_head[OP_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    issue_state_t        r_state,     w_state_nxt;
    logic                r_alu_rst,   w_alu_rst_nxt;
    logic                r_alu_valid, w_alu_valid_nxt;
    logic [c_OPW-1:0]    r_alu_op,    w_alu_op_nxt;
    logic [OP_WIDTH-1:0] r_alu_a,     w_alu_a_nxt;
    logic [OP_WIDTH-1:0] r_alu_b,     w_alu_b_nxt;
    logic [c_RC_W-1:0]   r_rcnt,      w_rcnt_nxt;
    logic                w_issue;
    logic                w_rst_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_alu_rst   <= 1'b0;
            r_alu_valid <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rcnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_alu_rst   <= w_alu_rst_nxt;
            r_alu_valid <= w_alu_valid_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_rcnt      <= w_rcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_alu_rst_nxt   = r_alu_rst;
        w_alu_valid_nxt = r_alu_valid;
        w_alu_op_nxt    = r_alu_op;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_rcnt_nxt      = r_rcnt;
        w_pop           = 1'b0;
        w_issue         = 1'b0;
        w_rst_entry     = 1'b0;
        case (r_state)
            IDLE: begin
                // Releases alu_rst on the first cycle out of reset.
                w_alu_rst_nxt = 1'b1;
                if (!w_empty) begin
                    if (w_head_op == rst_op) begin
                        // The reset sequence does not wait for alu_ready.
                        w_pop         = 1'b1;
                        w_rst_entry   = 1'b1;
                        w_alu_rst_nxt = 1'b0;
                        w_alu_op_nxt  = rst_op;
                        w_rcnt_nxt    = c_RA_LOAD;
                        w_state_nxt   = RST_ASSERT;
                    end else if (bus.alu_ready) begin
                        w_pop           = 1'b1;
                        w_issue         = 1'b1;
                        w_alu_valid_nxt = 1'b1;
                        w_alu_op_nxt    = w_head_op;
                        w_alu_a_nxt     = w_head_a;
                        w_alu_b_nxt     = w_head_b;
                        w_state_nxt     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_alu_valid_nxt = 1'b0;
                w_alu_op_nxt    = '0;
                w_alu_a_nxt     = '0;
                w_alu_b_nxt     = '0;
                w_state_nxt     = IDLE;
            end
            RST_ASSERT: begin
                if (r_rcnt == '0) begin
                    w_alu_rst_nxt = 1'b1;
                    w_rcnt_nxt    = c_RR_LOAD;
                    w_state_nxt   = RST_RECOVER;
                end else begin
                    w_rcnt_nxt = r_rcnt - c_RC_W'(1);
                end
            end
            RST_RECOVER: begin
                if (r_rcnt == '0) begin
                    w_alu_op_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_rcnt_nxt = r_rcnt - c_RC_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.alu_rst    = r_alu_rst;
    assign bus.alu_valid  = r_alu_valid;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.busy       = !w_empty || (r_state != IDLE);
    assign bus.fifo_count = w_count;

`ifdef ALU_IN_ISSUE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating activity counters
    // ------------------------------------------------------------------
    logic [15:0] r_issued_cnt;
    logic [15:0] r_reset_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= '0;
            r_reset_cnt  <= '0;
        end else begin
            if (w_issue && (r_issued_cnt != 16'hFFFF)) begin
                r_issued_cnt <= r_issued_cnt + 16'd1;
            end
            if (w_rst_entry && (r_reset_cnt != 16'hFFFF)) begin
                r_reset_cnt <= r_reset_cnt + 16'd1;
            end
        end
    end

    assign issued_count = r_issued_cnt;
    assign reset_count  = r_reset_cnt;
`endif

endmodule : alu_in_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_in_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_in_issue_ctrl
// Description : Self-checking bench for alu_in_issue_ctrl. A request-level
//               model (round-robin pointer, occupancy, queue of expected
//               issues) predicts grants and issued operations; a monitor
//               compares every alu_valid pulse and alu_rst sequence against
//               the expected queue. Directed scenarios check latency, stall,
//               reset-op timing and mid-operation reset.
//               Define ALU_IN_ISSUE_STATS_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_in_issue_ctrl;
    import alu_in_issue_pkg::*;

    localparam int OP_WIDTH   = 8;
    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_in_issue_ctrl_if #(
        .OP_WIDTH   (OP_WIDTH),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

`ifdef ALU_IN_ISSUE_STATS_EN
    logic [15:0] issued_count;
    logic [15:0] reset_count;
`endif

    alu_in_issue_ctrl #(
        .OP_WIDTH           (OP_WIDTH),
        .NUM_CH             (NUM_CH),
        .FIFO_DEPTH         (FIFO_DEPTH),
        .RST_ASSERT_CYCLES  (10),
        .RST_RECOVER_CYCLES (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_IN_ISSUE_STATS_EN
        ,
        .issued_count (issued_count),
        .reset_count  (reset_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Request-level model state.
    ent_t exp_q[$];
    int   model_count = 0;
    int   model_ptr   = 0;

    // Stimulus for the next cycle.
    logic [NUM_CH-1:0] t_valid;
    logic [2:0]        t_op [NUM_CH];
    logic [7:0]        t_a  [NUM_CH];
    logic [7:0]        t_b  [NUM_CH];
    logic              t_ready;

    // Monitor state.
    bit m_in_rst   = 1'b0;
    int m_low      = 0;
    int m_quiet    = 0;
    bit m_prev_rst = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [2:0] rand_plain_op();
        int r;
        r = int'($urandom_range(0, 4));
        return 3'(r);
    endfunction

    task automatic set_idle();
        for (int i = 0; i < NUM_CH; i++) begin
            t_valid[i] = 1'b0;
            t_op[i]    = no_op;
            t_a[i]     = 8'h00;
            t_b[i]     = 8'h00;
        end
    endtask

    task automatic set_req(input int ch, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        t_valid[ch] = 1'b1;
        t_op[ch]    = op;
        t_a[ch]     = a;
        t_b[ch]     = b;
    endtask

    // Drive one cycle of stimulus, predict the grant, check it, and record
    // the accepted entry as an expected issue.
    task automatic step();
        logic [NUM_CH-1:0] exp_rdy;
        int g;
        @(negedge clk);
        bus.ch_valid = t_valid;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_op[3*i +: 3] = t_op[i];
            bus.ch_a[8*i +: 8]  = t_a[i];
            bus.ch_b[8*i +: 8]  = t_b[i];
        end
        bus.alu_ready = t_ready;
        #1;
        exp_rdy = '0;
        g = -1;
        if (model_count < FIFO_DEPTH) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (model_ptr + k) % NUM_CH;
                if (g < 0 && t_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ch_ready", 64'(bus.ch_ready), 64'(exp_rdy));
        chk("fifo_count", 64'(bus.fifo_count), 64'(model_count));
        if (g >= 0) begin
            exp_q.push_back('{op: t_op[g], a: t_a[g], b: t_b[g]});
            model_ptr = (g + 1) % NUM_CH;
            model_count++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ch_valid  = '1;
        bus.alu_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_alu_rst", 64'(bus.alu_rst), 64'(0));
        chk("rst_alu_valid", 64'(bus.alu_valid), 64'(0));
        chk("rst_alu_op_a_b", 64'({bus.alu_op, bus.alu_a, bus.alu_b}), 64'(0));
        chk("rst_ch_ready", 64'(bus.ch_ready), 64'(0));
        chk("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        exp_q.delete();
        model_count = 0;
        model_ptr   = 0;
        bus.ch_valid = '0;
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("alu_rst_release", 64'(bus.alu_rst), 64'(1));
    endtask

    // Scoreboard monitor: every issue pulse and every alu_rst sequence
    // consumes the oldest expected entry.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            m_in_rst   = 1'b0;
            m_low      = 0;
            m_quiet    = 0;
            m_prev_rst = 1'b0;
        end else begin
            if (m_in_rst || m_quiet > 0) begin
                chk("no_issue_in_rst_seq", 64'(bus.alu_valid), 64'(0));
            end
            if (bus.alu_valid === 1'b1) begin
                chk("issue_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    model_count--;
                    chk("issue_op", 64'(bus.alu_op), 64'(e.op));
                    chk("issue_a", 64'(bus.alu_a), 64'(e.a));
                    chk("issue_b", 64'(bus.alu_b), 64'(e.b));
                end
            end
            if (m_prev_rst && !bus.alu_rst) begin
                chk("rst_seq_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    model_count--;
                    chk("rst_seq_entry_op", 64'(e.op), 64'(rst_op));
                end
                chk("rst_seq_alu_op", 64'(bus.alu_op), 64'(rst_op));
                m_in_rst = 1'b1;
                m_low    = 1;
            end else if (m_in_rst) begin
                if (!bus.alu_rst) begin
                    m_low++;
                end else begin
                    chk("alu_rst_low_cycles", 64'(m_low), 64'(10));
                    m_in_rst = 1'b0;
                    m_quiet  = 5;
                end
            end else if (m_quiet > 0) begin
                m_quiet--;
            end
            m_prev_rst = bus.alu_rst;
        end
    end

    initial begin
        int first_valid;
        int low_cnt;

        set_idle();
        t_ready       = 1'b0;
        bus.ch_valid  = '0;
        bus.ch_op     = '0;
        bus.ch_a      = '0;
        bus.ch_b      = '0;
        bus.alu_ready = 1'b0;
        apply_reset();

        // Single op latency: accept at N, valid visible after N+1.
        t_ready = 1'b1;
        set_idle();
        set_req(0, add_op, 8'h12, 8'h34);
        step();
        set_idle();
        step();
        chk("single_valid_n0", 64'(bus.alu_valid), 64'(0));
        chk("single_busy_n0", 64'(bus.busy), 64'(1));
        step();
        chk("single_valid_n1", 64'(bus.alu_valid), 64'(1));
        step();
        chk("single_valid_n2", 64'(bus.alu_valid), 64'(0));
        chk("single_busy_n2", 64'(bus.busy), 64'(0));

        // Round-robin fill with the ALU stalled.
        apply_reset();
        t_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_req(c, rand_plain_op(), 8'($urandom), 8'($urandom));
            end
            step();
        end
        chk("rr_full_count", 64'(bus.fifo_count), 64'(FIFO_DEPTH));
        chk("rr_full_ready", 64'(bus.ch_ready), 64'(0));
        set_idle();
        t_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();

        // Ready stall: queued xor_op waits for alu_ready.
        t_ready = 1'b0;
        set_req(0, xor_op, 8'hA5, 8'h5A);
        step();
        set_idle();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("stall_no_valid", 64'(bus.alu_valid), 64'(0));
        end
        t_ready = 1'b1;
        step();
        chk("stall_no_valid_pre", 64'(bus.alu_valid), 64'(0));
        step();
        chk("stall_issue", 64'(bus.alu_valid), 64'(1));
        for (int i = 0; i < 3; i++) step();

        // Reset op followed by mul_op; alu_ready low when rst_op is at head.
        t_ready = 1'b0;
        set_req(0, rst_op, 8'h00, 8'h00);
        step();
        set_idle();
        set_req(1, mul_op, 8'h05, 8'h06);
        step();
        first_valid = -1;
        low_cnt = (bus.alu_rst === 1'b0) ? 1 : 0;
        set_idle();
        t_ready = 1'b1;
        for (int j = 3; j <= 28; j++) begin
            step();
            if (bus.alu_rst === 1'b0) low_cnt++;
            if (first_valid < 0 && bus.alu_valid === 1'b1) first_valid = j;
        end
        chk("rstop_low_total", 64'(low_cnt), 64'(10));
        chk("rstop_mul_issue_step", 64'(first_valid), 64'(19));

        // Mid-operation reset with three entries queued.
        t_ready = 1'b0;
        set_req(0, rst_op, 8'h00, 8'h00);
        step();
        set_idle(); set_req(0, mul_op, 8'h11, 8'h22); step();
        set_idle(); set_req(0, add_op, 8'h33, 8'h44); step();
        set_idle(); set_req(0, and_op, 8'h55, 8'h66); step();
        set_idle();
        step();
        chk("midrst_alu_rst_low", 64'(bus.alu_rst), 64'(0));
        chk("midrst_count", 64'(bus.fifo_count), 64'(3));
        apply_reset();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                t_valid[c] = 1'($urandom_range(0, 1));
                t_op[c]    = ($urandom_range(0, 11) == 0) ? rst_op : rand_plain_op();
                t_a[c]     = 8'($urandom);
                t_b[c]     = 8'($urandom);
            end
            t_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        set_idle();
        t_ready = 1'b1;
        for (int i = 0; i < 100; i++) step();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        chk("drain_busy", 64'(bus.busy), 64'(0));

`ifdef ALU_IN_ISSUE_STATS_EN
        apply_reset();
        t_ready = 1'b1;
        set_idle(); set_req(0, add_op, 8'h01, 8'h02); step();
        set_idle(); set_req(0, rst_op, 8'h00, 8'h00); step();
        set_idle(); set_req(0, and_op, 8'h03, 8'h04); step();
        set_idle(); set_req(0, xor_op, 8'h05, 8'h06); step();
        set_idle();
        for (int i = 0; i < 40; i++) step();
        chk("stats_issued", 64'(issued_count), 64'(3));
        chk("stats_reset", 64'(reset_count), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_in_issue_ctrl
`default_nettype wire
